// File: rtl/store_unit.sv
// store_unit: S-type store execution with byte strobes, memory handshake and watchdog
module store_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic [11:0] imm,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  output logic        done,
  output logic [1:0]  status,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [1:0] status_q, status_d;
  logic [31:0] ea;
  logic is_sb, is_sh, is_sw, misaligned;
  assign ea = rs1_val + {{20{imm[11]}}, imm};
  assign is_sb = funct3 == 3'b000;
  assign is_sh = funct3 == 3'b001;
  assign is_sw = funct3 == 3'b010;
  assign misaligned = (is_sh && ea[0]) || (is_sw && ea[1:0] != 2'b00);
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign mem_req   = state_q == REQ;
  assign done      = state_q == DONE;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign status    = status_q;
  // next-state: accept/decode in IDLE, handshake plus watchdog in REQ, single-cycle DONE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    status_d = status_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (!(is_sb || is_sh || is_sw)) begin
          state_d  = DONE;
          status_d = 2'b10;
        end else if (misaligned) begin
          state_d  = DONE;
          status_d = 2'b01;
        end else begin
          state_d = REQ;
          cnt_d   = '0;
          addr_d  = {ea[31:2], 2'b00};
          wstrb_d = is_sw ? 4'b1111 : (is_sh ? 4'b0011 : 4'b0001) << ea[1:0];
          wdata_d = is_sw ? rs2_val : is_sh ? {2{rs2_val[15:0]}} : {4{rs2_val[7:0]}};
        end
      end
      REQ: begin
        cnt_d = mem_ack ? cnt_q : cnt_q + 1'b1;
        if (mem_ack) begin
          state_d  = DONE;
          status_d = 2'b00;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d  = DONE;
          status_d = 2'b11;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      status_q <= status_d;
    end
  end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed and randomized checks of store_unit against a byte-lane reference model
module tb_store_unit;
  localparam int TIMEOUT = 16;
  logic        clk = 0, rst = 1, in_valid = 0, mem_ack = 0;
  logic [2:0]  funct3 = 0;
  logic [11:0] imm = 0;
  logic [31:0] rs1_val = 0, rs2_val = 0;
  logic        in_ready, mem_req, done, busy;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  status;
  int checks = 0, errors = 0;

  store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .imm(imm), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .done(done), .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: effective address, then per-byte lane selection from access size
  function automatic void model(input logic [2:0] f3, input logic [11:0] im,
                                input logic [31:0] base, input logic [31:0] data,
                                output logic [1:0] st, output logic [31:0] addr,
                                output logic [31:0] wd, output logic [3:0] strb);
    int size, off, simm;
    logic [31:0] ea;
    simm = $signed(im);
    ea = base + simm;
    size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    off = int'(ea % 4);
    st = (size == 0) ? 2'b10 : (ea % size != 0) ? 2'b01 : 2'b00;
    addr = ea - ea % 4;
    wd = 0;
    strb = 0;
    for (int b = 0; b < 4; b++) begin
      strb[b] = size != 0 && b >= off && b < off + size;
      if (size != 0) wd[8*b +: 8] = data[8*(b % size) +: 8];
    end
  endfunction

  // Issue one store; ack_delay >= TIMEOUT means memory never acknowledges
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [11:0] im,
                          input logic [31:0] base, input logic [31:0] data, input int ack_delay);
    logic [1:0] est;
    logic [31:0] eaddr, ewd;
    logic [3:0] estrb;
    int n, exp_n;
    model(f3, im, base, data, est, eaddr, ewd, estrb);
    funct3 = f3; imm = im; rs1_val = base; rs2_val = data; in_valid = 1;
    chk({tag, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    rs2_val = ~data;
    if (est != 2'b00) begin
      chk({tag, " err mem_req"}, mem_req, 0);
      chk({tag, " err done"}, done, 1);
      chk({tag, " err status"}, status, est);
    end else begin
      n = 0;
      exp_n = ack_delay < TIMEOUT ? ack_delay + 1 : TIMEOUT;
      while (1) begin
        mem_ack = (n == ack_delay);
        chk({tag, " mem_req"}, mem_req, 1);
        chk({tag, " mem_addr"}, mem_addr, eaddr);
        chk({tag, " mem_wstrb"}, mem_wstrb, estrb);
        chk({tag, " mem_wdata"}, mem_wdata, ewd);
        @(posedge clk); #1;
        n++;
        if (done || n > TIMEOUT + 2) break;
      end
      mem_ack = 0;
      chk({tag, " req cycles"}, n, exp_n);
      chk({tag, " done"}, done, 1);
      chk({tag, " mem_req off"}, mem_req, 0);
      chk({tag, " status"}, status, ack_delay < TIMEOUT ? 2'b00 : 2'b11);
    end
    chk({tag, " in_ready in DONE"}, in_ready, 0);
    @(posedge clk); #1;
    chk({tag, " done cleared"}, done, 0);
    chk({tag, " idle"}, busy, 0);
  endtask

  initial begin
    #2;
    chk("rst mem_req", mem_req, 0);
    chk("rst done", done, 0);
    chk("rst status", status, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_wstrb", mem_wstrb, 0);
    chk("rst busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("post-rst in_ready", in_ready, 1);

    do_store("sw aligned", 3'b010, 12'h004, 32'h1000, 32'hDEADBEEF, 2);
    do_store("sb neg imm", 3'b000, 12'hFFF, 32'h2000, 32'h12345678, 0);
    do_store("sh misaligned", 3'b001, 12'h000, 32'h3001, 32'hAAAA5555, 0);
    do_store("illegal f3", 3'b011, 12'h000, 32'h3000, 32'h1, 0);
    do_store("timeout", 3'b010, 12'h010, 32'h5000, 32'hCAFEF00D, TIMEOUT + 5);
    do_store("ack last cycle", 3'b010, 12'h010, 32'h5000, 32'hCAFEF00D, TIMEOUT - 1);

    funct3 = 3'b010; imm = 0; rs1_val = 32'h6000; rs2_val = 32'h11223344; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    chk("rstmid mem_req", mem_req, 1);
    #2 rst = 1;
    #1;
    chk("rstmid async drop", mem_req, 0);
    chk("rstmid busy", busy, 0);
    @(posedge clk); #1;
    chk("rstmid no done", done, 0);
    rst = 0;
    #1;
    chk("rstmid in_ready", in_ready, 1);
    @(posedge clk); #1;
    do_store("after rst sw", 3'b010, 12'h008, 32'h6000, 32'h55667788, 1);

    funct3 = 3'b001; imm = 12'h002; rs1_val = 32'h4000; rs2_val = 32'h0000BEEF; in_valid = 1;
    @(posedge clk); #1;
    chk("b2b first req", mem_req, 1);
    chk("b2b first addr", mem_addr, 32'h4000);
    chk("b2b first wstrb", mem_wstrb, 4'b1100);
    chk("b2b first wdata", mem_wdata, 32'hBEEFBEEF);
    mem_ack = 1;
    imm = 12'h000; rs2_val = 32'h0000C0DE;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("b2b first done", done, 1);
    chk("b2b first status", status, 0);
    @(posedge clk); #1;
    chk("b2b idle gap", mem_req, 0);
    @(posedge clk); #1;
    in_valid = 0;
    chk("b2b second req", mem_req, 1);
    chk("b2b second addr", mem_addr, 32'h4000);
    chk("b2b second wstrb", mem_wstrb, 4'b0011);
    chk("b2b second wdata", mem_wdata, 32'hC0DEC0DE);
    mem_ack = 1;
    @(posedge clk); #1;
    mem_ack = 0;
    chk("b2b second done", done, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      logic [2:0] f3;
      int ad;
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      ad = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3) : $urandom_range(0, 4);
      mem_ack = $urandom_range(0, 1) == 1;
      do_store("random", f3, 12'($urandom), $urandom, $urandom, ad);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
